// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, scan-code prefixes and the
// movement key codes consumed by the player logic.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_D = 8'h23;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronizers, frame FSM, inactivity timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  logic             fall_edge;
  logic             parity_ok;

  ps2_state_e       state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic [7:0]       byte_q;
  logic             valid_q;
  logic             err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_s2_q;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else if (fall_edge && state_q == ST_PARITY) begin
      parity_q <= dat_s2_q;
    end
  end

  assign parity_ok = ^{shift_q, parity_q};
`else
  // Parity bit is consumed by the PARITY state but never stored.
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (fall_edge) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (dat_s2_q && parity_ok) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          state_q   <= ST_IDLE;
          shift_q   <= '0;
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          err_q     <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix tracking and make/break of the current key.
// Optional parity enforcement in the receiver: define PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       keyPress,
  output logic       extended,
  output logic       byte_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic [7:0] keycode_q, keycode_d;
  logic       keypress_q, keypress_d;
  logic       extended_q, extended_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .ps2_clk_i   (PS2_CLK),
    .ps2_dat_i   (PS2_DAT),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  always_comb begin
    keycode_d  = keycode_q;
    keypress_d = keypress_q;
    extended_d = extended_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (rx_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        if (!brk_pend_q) begin
          keycode_d  = rx_byte;
          extended_d = ext_pend_q;
          keypress_d = 1'b1;
        end else if (rx_byte == keycode_q && ext_pend_q == extended_q) begin
          keypress_d = 1'b0;
        end
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      keycode_q  <= '0;
      keypress_q <= 1'b0;
      extended_q <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      keycode_q  <= keycode_d;
      keypress_q <= keypress_d;
      extended_q <= extended_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  // Key state is presented from the next-state view so it changes in the
  // same cycle as the byte_valid strobe rather than one cycle later.
  assign keycode    = keycode_d;
  assign keyPress   = keypress_d;
  assign extended   = extended_d;
  assign byte_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of Clk cycles without a PS2 clock falling edge after which a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 Clk  input  1  system clock; the only clock in the block.
REQ-003 Reset  input  1  reset, asynchronous and active-high.
REQ-004 PS2_CLK  input  1  raw keyboard clock, asynchronous to Clk.
REQ-005 PS2_DAT  input  1  raw keyboard data, asynchronous to Clk.
REQ-006 keycode  output  8  last accepted make code; this is the scan code consumed by the player movement logic.
REQ-007 keyPress  output  1  high while the key in keycode is held.
REQ-008 extended  output  1  high when the last accepted make code was E0-prefixed.
REQ-009 byte_valid  output  1  one-cycle pulse for every correctly received byte.
REQ-010 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer; a falling edge is synced clock 1->0 between consecutive cycles.
REQ-012 Frame SHALL be: start 0, 8 data bits LSB first, odd parity, stop 1; each bit sampled from synced PS2_DAT on a detected falling edge.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP.
- IDLE->DATA on an edge with data 0; data 1 stays IDLE with no error.
- DATA->PARITY after the 8th bit.
- PARITY->STOP on the next edge.
- STOP->IDLE on the next edge.
REQ-014 Byte SHALL be accepted when the stop bit is 1 and parity is odd over 9 bits (see REQ-023); byte_valid pulses exactly 1 Clk after the stop-bit edge is detected.
REQ-015 Stop bit 0 SHALL discard the byte and pulse frame_err; FSM returns to IDLE.
REQ-016 In any state other than IDLE, a counter reaching TIMEOUT_CYCLES with no edge SHALL return the FSM to IDLE, pulse frame_err once and clear the shift register; the counter clears on every edge.
REQ-017 Prefix decoding on accepted bytes:
- 0xE0 sets the ext_pending flag.
- 0xF0 sets the brk_pending flag.
- Any other byte is a code; both flags clear after a code.
REQ-018 Make code (brk_pending=0) SHALL set keycode=code, extended=ext_pending and keyPress=1, in the same cycle as byte_valid.
REQ-019 Break code SHALL clear keyPress only if code==keycode and ext_pending==extended; otherwise keycode, extended and keyPress are unchanged.
REQ-020 A repeated make (typematic) of the current key SHALL leave keyPress=1 with no glitch.
REQ-021 A frame error SHALL leave keycode, extended and keyPress unchanged, and SHALL NOT clear ext_pending or brk_pending.

Reset
REQ-022 Reset SHALL force, asynchronously and also mid-frame:
- FSM to IDLE; shift register, bit counter, timeout counter, both synchronizers (to 1) and both pending flags cleared;
- keycode=8'h00, keyPress=0, extended=0, byte_valid=0, frame_err=0.

Configuration
REQ-023 With macro PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL discard the byte and pulse frame_err. Undefined, the parity bit SHALL be sampled but ignored, and the byte is accepted if the stop bit is 1.

Structure
REQ-024 A shared package ps2_pkg SHALL hold the FSM state enum and constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0. Key constants KEY_W=8'h1D, KEY_A=8'h1C, KEY_S=8'h1B and KEY_D=8'h23 also belong there, for reuse by the player movement logic.
REQ-025 Sub-module ps2_rx_frame SHALL contain the synchronizers, FSM, timeout and parity logic, outputting byte+strobe+error. ps2_key_decoder SHALL contain the prefix/make/break logic.

Verification
REQ-026 Frame 0x1C (parity 0, stop 1) -> byte_valid pulse, keycode=0x1C, keyPress=1, extended=0.
REQ-027 Then frames F0,1C -> keyPress=0, keycode stays 0x1C; F0,23 instead -> keyPress stays 1.
REQ-028 Frames E0,75 -> keycode=0x75, extended=1, keyPress=1; a plain break F0,75 afterwards -> keyPress stays 1.
REQ-029 Frame 0x23 with parity bit 1 -> macro defined: frame_err pulse, outputs unchanged; undefined: keycode=0x23.
REQ-030 Stop after 5 bits for TIMEOUT_CYCLES -> one frame_err pulse, FSM IDLE; the next valid 0x1D frame -> keycode=0x1D.
REQ-031 Reset asserted mid-frame after 0x1C held -> all outputs 0 immediately; a clean frame after release decodes correctly.
